dot_product_seq: RTL and testbench

DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

---
 rtl/dot_product_pkg.sv | 21 ++
 rtl/dot_product_mac.sv | 33 +++
 rtl/dot_product_seq.sv | 110 +++++++++++
 tb/tb_dot_product_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared types and width helper for the sequential dot product
//
// Purpose: holds the controller state encoding and the result-width function
//          used by dot_product_seq to size OW.
// Contents:
//   state_t       IDLE / RUN / DONE
//   result_width  2*dw + clog2(n): enough bits that n full-scale products never overflow

package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int result_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - combinational multiply-accumulate step acc + a*b
//
// Purpose: one MAC step of the dot product at the full result width.
// Configuration: DOT_PRODUCT_SEQ_SIGNED_EN defined -> a, b are two's complement
//                and the product is sign-extended; otherwise unsigned, zero-extended.
// Ports:
//   acc       in   OW  running sum
//   a, b      in   DW  current elements
//   acc_next  out  OW  acc + a*b

module dot_product_mac #(
  parameter int DW = 8,
  parameter int OW = 18
) (
  input  logic [OW-1:0] acc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [OW-1:0] acc_next
);

`ifdef DOT_PRODUCT_SEQ_SIGNED_EN
  logic signed [2*DW-1:0] prod;
  assign prod = $signed(a) * $signed(b);
`else
  logic [2*DW-1:0] prod;
  assign prod = a * b;
`endif

  // The size cast extends according to the signedness of prod, so the same
  // line gives zero-extension (unsigned) or sign-extension (signed build).
  assign acc_next = acc + OW'(prod);

endmodule

// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - sequential N-element dot product, one element per clock
//
// Purpose: captures two N-element vectors on a valid/ready handshake, accumulates
//          A[i]*B[i] over N cycles and presents the sum until the consumer takes it.
// Configuration: DOT_PRODUCT_SEQ_SIGNED_EN selects two's-complement elements/result.
// Ports:
//   clock      in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   in_valid   in   1     request carries a vector pair
//   in_ready   out  1     request accepted this cycle
//   inp1/inp2  in   N*DW  vectors A/B, element i at [(i+1)*DW-1 : i*DW]
//   out_valid  out  1     outp holds a completed result
//   out_ready  in   1     consumer takes the result this cycle
//   outp       out  OW    sum of A[i]*B[i]
//   busy       out  1     accumulating

module dot_product_seq
  import dot_product_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int OW = result_width(N, DW)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] inp1,
  input  logic [N*DW-1:0] inp2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] outp,
  output logic          busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t          state, state_next;
  logic [N*DW-1:0] a_reg, b_reg;
  logic [OW-1:0]   acc, acc_next;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   a_elem, b_elem;
  logic            accept;

  // Accepting in DONE while the consumer takes the result gives back-to-back
  // operation with no idle cycle between results.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign outp      = acc;

  assign a_elem = a_reg[idx*DW +: DW];
  assign b_elem = b_reg[idx*DW +: DW];

  dot_product_mac #(
    .DW(DW),
    .OW(OW)
  ) u_mac (
    .acc     (acc),
    .a       (a_elem),
    .b       (b_elem),
    .acc_next(acc_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (idx == LAST_IDX) state_next = DONE;
      DONE: begin
        if (accept) begin
          state_next = RUN;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched on accept so the requester may change inp1/inp2
  // freely while the sum is being built.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      idx   <= '0;
    end else if (accept) begin
      a_reg <= inp1;
      b_reg <= inp2;
      acc   <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      idx <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// tb/tb_dot_product_seq.sv - self-checking bench for dot_product_seq

module tb_dot_product_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 2 * DW + $clog2(N);

`ifdef DOT_PRODUCT_SEQ_SIGNED_EN
  localparam logic [31:0] EXP_FF = 32'd4;
`else
  localparam logic [31:0] EXP_FF = 32'd260100;
`endif

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] inp1, inp2;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] outp;
  logic          busy;

  dot_product_seq #(.N(N), .DW(DW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inp1     (inp1),
    .inp2     (inp2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outp     (outp),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
`ifdef DOT_PRODUCT_SEQ_SIGNED_EN
      s += int'($signed(a[i*DW +: DW])) * int'($signed(b[i*DW +: DW]));
`else
      s += int'(a[i*DW +: DW]) * int'(b[i*DW +: DW]);
`endif
    end
    return OW'(s);
  endfunction

  // Reference: an accepted request owns the block until it is released; its
  // result becomes visible N edges after the accepting edge.
  int            cyc = 0;
  bit            m_op = 0;
  int            m_done = 0;
  logic [OW-1:0] m_res = '0;
  int            n_released = 0;
  int            ov_cycles = 0;
  logic [OW-1:0] last_outp = '0;
  bit            e_ov, e_ir;

  always @(posedge clock) begin
    e_ov = m_op && (cyc >= m_done);
    e_ir = !m_op || (e_ov && out_ready);
    if (!reset_n) begin
      m_op = 0;
    end else begin
      cyc++;
      if (e_ov && out_ready) n_released++;
      if (in_valid && e_ir) begin
        m_op   = 1;
        m_done = cyc + N;
        m_res  = dot(inp1, inp2);
      end else if (e_ov && out_ready) begin
        m_op = 0;
      end
    end
    #1;
    if (!reset_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outp", 32'(outp), 32'd0);
    end else begin
      e_ov = m_op && (cyc >= m_done);
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("busy", 32'(busy), 32'(m_op && !e_ov));
      chk("in_ready", 32'(in_ready), 32'(!m_op || (e_ov && out_ready)));
      if (e_ov) chk("outp", 32'(outp), 32'(m_res));
    end
    if (out_valid) begin
      last_outp = outp;
      ov_cycles++;
    end
  end

  // Stimulus: inputs change only just after a falling edge.
  int  or_mode = 0;   // 0: out_ready=1, 1: random, 2: held by the caller
  bit  hs = 0;
  bit  req_pending = 0;
  int  n0, oc0;

  task automatic clk_step();
    if (or_mode == 0) out_ready = 1'b1;
    else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    #1 hs = in_valid && in_ready;
    @(negedge clock);
    if (hs) req_pending = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      inp1 = $urandom;
      inp2 = $urandom;
      clk_step();
    end
  endtask

  task automatic submit(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    int budget;
    budget = 0;
    req_pending = 1;
    while (req_pending && budget < 50) begin
      in_valid = 1'b1;
      inp1 = a;
      inp2 = b;
      clk_step();
      budget++;
    end
    if (req_pending) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_pending = 0;
    end
    in_valid = 1'b0;
    inp1 = $urandom;
    inp2 = $urandom;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    inp1      = '0;
    inp2      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_outp", 32'(outp), 32'd0);
    reset_n = 1'b1;

    // Basic sum, consumer always ready.
    n0 = n_released;
    submit(32'h04030201, 32'h02020202);
    idle(N + 2);
    chk("t1_outp", 32'(last_outp), 32'd20);
    chk("t1_count", 32'(n_released - n0), 32'd1);

    // Full-scale elements.
    submit(32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(N + 2);
    chk("t2_outp", 32'(last_outp), EXP_FF);

    // Consumer stalls in DONE while the inputs wander.
    or_mode = 2;
    out_ready = 1'b0;
    submit(32'h04030201, 32'h08070605);
    idle(N + 6);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    chk("t3_outp", 32'(outp), 32'd70);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    idle(1);
    chk("t3_released", 32'(out_valid), 32'd0);
    or_mode = 0;

    // Back-to-back requests.
    n0 = n_released;
    oc0 = ov_cycles;
    submit(32'h04030201, 32'h01010101);
    submit(32'h01010101, 32'h03030303);
    idle(N + 3);
    chk("t4_count", 32'(n_released - n0), 32'd2);
    chk("t4_ov_cycles", 32'(ov_cycles - oc0), 32'd2);
    chk("t4_outp", 32'(last_outp), 32'd12);

    // Reset while accumulating at idx 2.
    submit(32'h04030201, 32'h02020202);
    idle(2);
    reset_n = 1'b0;
    n0 = n_released;
    oc0 = ov_cycles;
    idle(2);
    reset_n = 1'b1;
    submit(32'h281E140A, 32'h01010101);
    idle(N + 2);
    chk("t5_count", 32'(n_released - n0), 32'd1);
    chk("t5_ov_cycles", 32'(ov_cycles - oc0), 32'd1);
    chk("t5_outp", 32'(last_outp), 32'd100);

`ifdef DOT_PRODUCT_SEQ_SIGNED_EN
    submit(32'hFFFFFFFF, 32'h01010101);
    idle(N + 2);
    chk("s1_outp", 32'(last_outp), 32'(18'h3FFFC));
    submit(32'h80808080, 32'h80808080);
    idle(N + 2);
    chk("s2_outp", 32'(last_outp), 32'd65536);
`endif

    // Random traffic with a random consumer.
    or_mode = 1;
    n0 = n_released;
    for (int k = 0; k < 150; k++) begin
      submit($urandom, $urandom);
      idle($urandom_range(0, 2));
    end
    or_mode = 0;
    idle(N + 3);
    chk("rand_count", 32'(n_released - n0), 32'd150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
